// File: rtl/life_display_scan_if.sv
// rtl/life_display_scan_if.sv - cell-array-to-LED-matrix bundle for life_display_scan
interface life_display_scan_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  localparam int POP_W = $clog2(ROWS*COLS+1);

  logic [ROWS*COLS-1:0] existence;
  logic                 gen_tick;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_data;
  logic                 frame_done;
  logic [POP_W-1:0]     population;
  logic [15:0]          gen_count;

  modport master (
    output existence, gen_tick,
    input  row_sel, col_data, frame_done, population, gen_count
  );

  modport slave (
    input  existence, gen_tick,
    output row_sel, col_data, frame_done, population, gen_count
  );
endinterface

// File: rtl/life_display_scan.sv
// rtl/life_display_scan.sv - tear-free row-multiplexed LED scan of the life cell array
module life_display_scan #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ROW_DWELL = 1024,
  parameter int BLANK     = 4
) (
  input logic                Clock,
  input logic                reset,
  life_display_scan_if.slave bus
);
  localparam int POP_W = $clog2(ROWS*COLS+1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;

  logic [RW-1:0]        r;
  logic [DW-1:0]        d;
  logic [ROWS*COLS-1:0] frame_buf;
  logic                 pending;
  logic [POP_W-1:0]     acc;
  logic [POP_W-1:0]     population;
  logic [15:0]          gen_count;
  logic                 frame_done;

  logic [COLS-1:0]      row_bits;
  logic [POP_W-1:0]     row_pop;
  logic                 last_dwell;
  logic                 last_row;
  logic                 drive;

  function automatic logic [POP_W-1:0] count_ones(input logic [COLS-1:0] bits);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + POP_W'(bits[i]);
    return n;
  endfunction

  assign row_bits   = frame_buf[r*COLS +: COLS];
  assign row_pop    = count_ones(row_bits);
  assign last_dwell = (d == DW'(ROW_DWELL-1));
  assign last_row   = (r == RW'(ROWS-1));
  // Compared in 32 bits so BLANK=0 never wraps the threshold into the counter width.
  assign drive      = (int'(d) < ROW_DWELL - BLANK);

  assign bus.row_sel    = drive ? (ROWS'(1) << r) : '0;
  assign bus.col_data   = drive ? row_bits : '0;
  assign bus.frame_done = frame_done;
  assign bus.population = population;
  assign bus.gen_count  = gen_count;

  always_ff @(posedge Clock) begin
    if (reset) begin
      r          <= '0;
      d          <= '0;
      frame_buf  <= '0;
      pending    <= 1'b0;
      acc        <= '0;
      population <= '0;
      gen_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!last_dwell) begin
        d <= d + DW'(1);
        if (bus.gen_tick) pending <= 1'b1;
      end else begin
        d <= '0;
        if (!last_row) begin
          r   <= r + RW'(1);
          acc <= acc + row_pop;
          if (bus.gen_tick) pending <= 1'b1;
        end else begin
          // Frame boundary: population uses the buffer shown this frame, before capture.
          r          <= '0;
          acc        <= '0;
          population <= acc + row_pop;
          frame_done <= 1'b1;
          if (pending || bus.gen_tick) begin
            frame_buf <= bus.existence;
            gen_count <= gen_count + 16'd1;
            pending   <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_life_display_scan.sv
// tb/tb_life_display_scan.sv - self-checking bench for life_display_scan
module tb_life_display_scan;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DWELL = 8;
  localparam int BL    = 2;
  localparam int FRAME = ROWS*DWELL;

  logic Clock = 1'b0;
  logic reset;
  always #5 Clock = ~Clock;

  life_display_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  life_display_scan #(.ROWS(ROWS), .COLS(COLS), .ROW_DWELL(DWELL), .BLANK(BL)) dut (
    .Clock(Clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: cycles since reset, displayed image, coalesced tick flag
  int          t;
  logic [15:0] m_buf;
  bit          m_pend;
  logic [15:0] m_gen;
  int          m_pop;
  bit          m_fd;

  typedef struct {
    logic [15:0] exist;
    int          tick;
    int          pop;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at t=%0d", name, act, exp, t);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      t = 0; m_buf = '0; m_pend = 0; m_gen = '0; m_pop = 0; m_fd = 0;
    end else begin
      m_fd = 0;
      if (t % FRAME == FRAME-1) begin
        m_pop = $countones(m_buf);
        if (m_pend || bus.gen_tick) begin
          m_buf  = bus.existence;
          m_gen  = m_gen + 16'd1;
          m_pend = 0;
        end
        m_fd = 1;
      end else if (bus.gen_tick) begin
        m_pend = 1;
      end
      t++;
    end
  endtask

  task automatic check_model();
    int row;
    bit drive;
    logic [3:0] exp_row;
    logic [3:0] exp_col;
    row   = (t / DWELL) % ROWS;
    drive = (t % DWELL) < (DWELL - BL);
    exp_row = drive ? 4'(1 << row) : 4'h0;
    exp_col = drive ? m_buf[row*COLS +: COLS] : 4'h0;
    check("row_sel", 32'(bus.row_sel), 32'(exp_row));
    check("col_data", 32'(bus.col_data), 32'(exp_col));
    check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check("population", 32'(bus.population), 32'(m_pop));
    check("gen_count", 32'(bus.gen_count), 32'(m_gen));
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.gen_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.gen_tick = 1'b0;
    bus.existence = '0;
    t = 0; m_buf = '0; m_pend = 0; m_gen = '0; m_pop = 0; m_fd = 0;

    vecs[0] = '{16'h8421, 5, 4};
    vecs[1] = '{16'hFFFF, 31, 16};
    vecs[2] = '{16'h0F30, 0, 6};
    vecs[3] = '{16'h1234, 20, 5};

    // reset state and idle scan
    do_reset();
    check("rst_row_sel", 32'(bus.row_sel), 32'h1);
    check("rst_col_data", 32'(bus.col_data), 32'h0);
    check("rst_population", 32'(bus.population), 32'h0);
    check("rst_gen_count", 32'(bus.gen_count), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    while (t < 2*FRAME + 1) begin
      bus.existence = 16'($urandom);
      step();
      if (t == 6)  check("idle_blank", 32'(bus.row_sel), 32'h0);
      if (t == 8)  check("idle_row1", 32'(bus.row_sel), 32'h2);
      if (t == 31) check("idle_fd_early", 32'(bus.frame_done), 32'h0);
      if (t == 32 || t == 64) check("idle_fd", 32'(bus.frame_done), 32'h1);
      if (t == 33) check("idle_fd_len", 32'(bus.frame_done), 32'h0);
    end
    check("idle_gen_count", 32'(bus.gen_count), 32'h0);

    // directed capture vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int c = 0; c < FRAME; c++) begin
        bus.existence = (c == FRAME-1) ? vecs[v].exist : 16'($urandom);
        bus.gen_tick  = (c == vecs[v].tick);
        step();
        if (c == FRAME-2) check("vec_no_early", 32'(bus.col_data), 32'h0);
      end
      bus.gen_tick = 1'b0;
      check("vec_fd", 32'(bus.frame_done), 32'h1);
      check("vec_gen", 32'(bus.gen_count), 32'h1);
      while (t < 2*FRAME) begin
        bus.existence = 16'($urandom);
        step();
        if ((t % DWELL) == 1) begin
          automatic logic [15:0] ex = vecs[v].exist;
          automatic int row = (t / DWELL) % ROWS;
          check("vec_col", 32'(bus.col_data), 32'(ex[row*COLS +: COLS]));
        end
      end
      check("vec_pop", 32'(bus.population), 32'(vecs[v].pop));
    end

    // several ticks in one frame coalesce into one capture of the boundary value
    do_reset();
    for (int c = 0; c < FRAME; c++) begin
      bus.gen_tick  = (c == 3 || c == 12 || c == 25);
      bus.existence = (c == FRAME-1) ? 16'h5A5A : 16'(c * 16'h1111);
      step();
    end
    bus.gen_tick = 1'b0;
    check("coal_col", 32'(bus.col_data), 32'hA);
    check("coal_gen", 32'(bus.gen_count), 32'h1);
    while (t < 2*FRAME + 1) step();
    check("coal_gen_after", 32'(bus.gen_count), 32'h1);

    // reset mid-frame discards a pending tick
    do_reset();
    for (int c = 0; c < 21; c++) begin
      bus.existence = 16'hFFFF;
      bus.gen_tick  = (c == 10);
      reset         = (c == 20);
      step();
    end
    bus.gen_tick = 1'b0;
    reset = 1'b0;
    check("mid_rst_row", 32'(bus.row_sel), 32'h1);
    for (int c = 0; c < 11; c++) step();
    check("mid_rst_fd", 32'(bus.frame_done), 32'h0);
    check("mid_rst_gen", 32'(bus.gen_count), 32'h0);
    while (t < FRAME + 1) step();
    check("mid_rst_gen_bnd", 32'(bus.gen_count), 32'h0);
    check("mid_rst_col", 32'(bus.col_data), 32'h0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.existence = 16'($urandom);
      bus.gen_tick  = ($urandom_range(0, 11) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
